i2s_rate_sequencer: RTL and testbench

//  APB master FSM that reprograms the I2S clock-control slave (reg1 @0x00, reg2 @0x04) for a new sample rate.

---
 rtl/i2s_rate_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_i2s_rate_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rate_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : i2s_rate_sequencer
// Brief   : APB master that mutes, reprograms and re-enables the I2S clock block
// Revision: 1.0
// ============================================================================
module i2s_rate_sequencer #(
    parameter int SETTLE_CYCLES = 64,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rate_req,
    input  logic [2:0]  rate_sel,
    input  logic        master_en,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [2:0]  cur_rate,
    output logic [4:0]  paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready
);

    localparam logic [15:0] c_settle_last = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] c_tmo_last    = 16'(TIMEOUT - 1);
    localparam logic [7:0]  c_mdiv        = 8'h00;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_DECODE = 4'd1,
        S_W1     = 4'd2,
        S_SETTLE = 4'd3,
        S_W2     = 4'd4,
        S_W3     = 4'd5,
        S_RB     = 4'd6,
        S_CHECK  = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t      r_state;
    logic        r_access;
    logic [15:0] r_tcnt;
    logic [15:0] r_scnt;
    logic [2:0]  r_sel;
    logic        r_men;
    logic [31:0] r_rdata;

    logic        w_valid;
    logic        w_csel;
    logic [7:0]  w_bdiv;
    logic [7:0]  w_lr;
    logic [31:0] w_r1mute;
    logic [31:0] w_r2;
    logic [31:0] w_r1run;

    always_comb begin
        w_valid = 1'b1;
        w_csel  = 1'b0;
        w_bdiv  = 8'd0;
        w_lr    = 8'd0;
        case (r_sel)
            3'd0: begin w_bdiv = 8'd3; w_lr = 8'd15; end
            3'd1: begin w_bdiv = 8'd1; w_lr = 8'd7;  end
            3'd2: begin w_bdiv = 8'd5; w_lr = 8'd23; end
            3'd3: begin w_csel = 1'b1; w_bdiv = 8'd5; w_lr = 8'd23; end
            3'd4: begin w_csel = 1'b1; w_bdiv = 8'd2; w_lr = 8'd11; end
            default: w_valid = 1'b0;
        endcase
    end

    assign w_r1mute = {c_mdiv, w_bdiv, 14'b0, w_csel, 1'b0};
    assign w_r2     = {16'b0, w_lr, w_lr};
    assign w_r1run  = w_r1mute | {31'b0, r_men};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_access <= 1'b0;
            r_tcnt   <= 16'd0;
            r_scnt   <= 16'd0;
            r_sel    <= 3'd0;
            r_men    <= 1'b0;
            r_rdata  <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            cur_rate <= 3'd0;
            paddr    <= 5'd0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            pwdata   <= 32'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rate_req) begin
                        r_sel    <= rate_sel;
                        r_men    <= master_en;
                        err_code <= 2'b00;
                        busy     <= 1'b1;
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_valid) begin
                        psel     <= 1'b1;
                        pwrite   <= 1'b1;
                        paddr    <= 5'h00;
                        pwdata   <= w_r1mute;
                        r_access <= 1'b0;
                        r_state  <= S_W1;
                    end else begin
                        err_code <= 2'b01;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_SETTLE: begin
                    if (r_scnt == c_settle_last) begin
                        psel    <= 1'b1;
                        pwrite  <= 1'b1;
                        paddr   <= 5'h04;
                        pwdata  <= w_r2;
                        r_state <= S_W2;
                    end else begin
                        r_scnt <= r_scnt + 16'd1;
                    end
                end
                S_W1, S_W2, S_W3, S_RB: begin
                    if (!r_access) begin
                        penable  <= 1'b1;
                        r_access <= 1'b1;
                        r_tcnt   <= 16'd0;
                    end else if (pready) begin
                        penable  <= 1'b0;
                        r_access <= 1'b0;
                        // W2->W3->RB run back to back: psel stays high into the next setup
                        case (r_state)
                            S_W1: begin
                                psel    <= 1'b0;
                                r_scnt  <= 16'd0;
                                r_state <= S_SETTLE;
                            end
                            S_W2: begin
                                paddr   <= 5'h00;
                                pwdata  <= w_r1run;
                                r_state <= S_W3;
                            end
                            S_W3: begin
                                pwrite  <= 1'b0;
                                paddr   <= 5'h00;
                                pwdata  <= 32'd0;
                                r_state <= S_RB;
                            end
                            default: begin
                                psel    <= 1'b0;
                                r_rdata <= prdata;
                                r_state <= S_CHECK;
                            end
                        endcase
                    end else if (r_tcnt == c_tmo_last) begin
                        psel     <= 1'b0;
                        penable  <= 1'b0;
                        pwrite   <= 1'b0;
                        r_access <= 1'b0;
                        err_code <= 2'b10;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                S_CHECK: begin
                    done    <= 1'b1;
                    r_state <= S_DONE;
                    if (r_rdata == w_r1run) begin
                        cur_rate <= r_sel;
                    end else begin
                        err_code <= 2'b11;
                        err      <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_rate_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2s_rate_sequencer
// Brief   : Randomized bench with APB slave model and rule-level reference model
// Revision: 1.0
// ============================================================================
module tb_i2s_rate_sequencer;

    localparam int S    = 4;
    localparam int TMO  = 8;
    localparam int MAXC = 400;

    logic        clk;
    logic        reset;
    logic        rate_req;
    logic [2:0]  rate_sel;
    logic        master_en;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [2:0]  cur_rate;
    logic [4:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    i2s_rate_sequencer #(.SETTLE_CYCLES(S), .TIMEOUT(TMO)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .rate_req  (rate_req),
        .rate_sel  (rate_sel),
        .master_en (master_en),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .cur_rate  (cur_rate),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // APB slave model
    logic [31:0] s_reg1 = 32'd0;
    logic [31:0] s_reg2 = 32'd0;
    int          max_wait = 0;
    int          waits = 0;
    int          acc4 = 0;
    bit          stall_w2 = 0;
    bit          corrupt = 0;
    logic [37:0] log_q[$];
    logic [37:0] exp_q[$];
    int          model_cur = 0;

    always @(negedge clk) begin
        if (psel && !penable) begin
            waits  = $urandom_range(0, max_wait);
            pready = 1'b0;
        end else if (psel && penable) begin
            if (paddr == 5'h04) acc4++;
            if (stall_w2 && pwrite && paddr == 5'h04) pready = 1'b0;
            else if (waits == 0) pready = 1'b1;
            else begin
                waits--;
                pready = 1'b0;
            end
        end else begin
            pready = 1'b0;
        end
        prdata = corrupt ? 32'hDEADBEEF : ((paddr == 5'h04) ? s_reg2 : s_reg1);
    end

    always @(posedge clk) begin
        if (psel && penable && pready) begin
            log_q.push_back({pwrite, paddr, pwrite ? pwdata : prdata});
            if (pwrite && paddr == 5'h00) s_reg1 = pwdata;
            if (pwrite && paddr == 5'h04) s_reg2 = pwdata;
        end
    end

    // Reference: register words straight from the rate table
    function automatic logic [31:0] ref_r1(input int sel, input bit men);
        int bd[5] = '{3, 1, 5, 5, 2};
        int cs[5] = '{0, 0, 0, 1, 1};
        return 32'(bd[sel] * 65536 + cs[sel] * 2 + int'(men));
    endfunction

    function automatic logic [31:0] ref_r2(input int sel);
        int lr[5] = '{15, 7, 23, 23, 11};
        return 32'(lr[sel] * 257);
    endfunction

    task automatic build_exp(input int sel, input bit men);
        exp_q.delete();
        if (sel > 4) return;
        exp_q.push_back({1'b1, 5'h00, ref_r1(sel, 1'b0)});
        if (stall_w2) return;
        exp_q.push_back({1'b1, 5'h04, ref_r2(sel)});
        exp_q.push_back({1'b1, 5'h00, ref_r1(sel, men)});
        exp_q.push_back({1'b0, 5'h00, corrupt ? 32'hDEADBEEF : ref_r1(sel, men)});
    endtask

    task automatic check_log(input string tag);
        int n;
        chk({tag, "_nxfer"}, 64'(log_q.size()), 64'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_xfer%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
    endtask

    task automatic start_req(input int sel, input bit men);
        @(negedge clk);
        log_q.delete();
        acc4      = 0;
        rate_sel  = 3'(sel);
        master_en = men;
        rate_req  = 1'b1;
        @(posedge clk);
        #1 rate_req = 1'b0;
    endtask

    task automatic do_seq(input string tag, input int sel, input bit men, input bit chk_lat,
                          input bit extra_req);
        int n;
        int exp_ec;
        int extra_done;
        build_exp(sel, men);
        exp_ec = (sel > 4) ? 1 : (stall_w2 ? 2 : (corrupt ? 3 : 0));
        if (exp_ec == 0) model_cur = sel;
        start_req(sel, men);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({tag, "_ec_clr"}, 64'(err_code), 64'd0);
                chk({tag, "_busy1"}, 64'(busy), 64'd1);
            end
            if (extra_req && n == 5) begin
                rate_sel  = 3'((sel + 1) % 5);
                master_en = ~men;
                rate_req  = 1'b1;
            end else begin
                rate_req = 1'b0;
            end
        end while (!done && n < MAXC);
        rate_req = 1'b0;
        chk({tag, "_done"}, 64'(done), 64'd1);
        if (chk_lat) chk({tag, "_lat"}, 64'(n), (sel > 4) ? 64'd2 : 64'(11 + S));
        chk({tag, "_err"}, 64'(err), 64'(exp_ec != 0));
        chk({tag, "_ec"}, 64'(err_code), 64'(exp_ec));
        chk({tag, "_cur"}, 64'(cur_rate), 64'(model_cur));
        check_log(tag);
        if (stall_w2 && sel <= 4) chk({tag, "_acc4"}, 64'(acc4), 64'(TMO));
        @(negedge clk);
        chk({tag, "_post_done"}, 64'(done), 64'd0);
        chk({tag, "_post_busy"}, 64'(busy), 64'd0);
        chk({tag, "_ec_hold"}, 64'(err_code), 64'(exp_ec));
        if (extra_req) begin
            extra_done = 0;
            repeat (30) begin
                @(negedge clk);
                if (done || busy) extra_done++;
            end
            chk({tag, "_no_second"}, 64'(extra_done), 64'd0);
        end
    endtask

    initial begin
        int k;
        int sel;
        bit men;
        bit lat;
        reset     = 1'b1;
        rate_req  = 1'b0;
        rate_sel  = 3'd0;
        master_en = 1'b0;
        prdata    = 32'd0;
        pready    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        chk("rst_ec", 64'(err_code), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_cur", 64'(cur_rate), 64'd0);
        reset = 1'b0;

        max_wait = 0;
        do_seq("r0", 0, 1'b1, 1'b1, 1'b0);
        do_seq("r3", 3, 1'b0, 1'b1, 1'b0);
        do_seq("inv6", 6, 1'b1, 1'b1, 1'b0);
        stall_w2 = 1'b1;
        do_seq("tmo", 1, 1'b1, 1'b0, 1'b0);
        stall_w2 = 1'b0;
        corrupt = 1'b1;
        do_seq("rbk", 4, 1'b1, 1'b1, 1'b0);
        corrupt = 1'b0;
        do_seq("busy_ign", 2, 1'b0, 1'b1, 1'b1);

        // Reset during the W3 write
        start_req(4, 1'b1);
        k = 0;
        while (!(log_q.size() == 2 && psel) && k < MAXC) begin
            @(negedge clk);
            k++;
        end
        chk("w3_reached", 64'(log_q.size() == 2 && psel), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_psel", 64'(psel), 64'd0);
        chk("mid_rst_penable", 64'(penable), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_cur = 0;
        chk("mid_rst_cur", 64'(cur_rate), 64'd0);
        do_seq("after_rst", 2, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            max_wait = $urandom_range(0, 3);
            sel      = $urandom_range(0, 7);
            men      = 1'($urandom_range(0, 1));
            corrupt  = ($urandom_range(0, 4) == 0);
            stall_w2 = ($urandom_range(0, 5) == 0);
            lat      = (max_wait == 0) && !stall_w2;
            do_seq($sformatf("rnd%0d", i), sel, men, lat, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
